multi_alarm: RTL and testbench

Parametrised multi-channel alarm for the digital clock. It holds `N_CH` independent HH:MM alarm settings in BCD and edits them with the same cursor/button scheme used for time setting. Each channel runs a ring/snooze state machine against the running clock's BCD digits. It sits beside the timekeeping counter and drives the buzzer/LED alert path.

---
 rtl/multi_alarm.sv | 226 ++++++++++++++++++++++
 tb/tb_multi_alarm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_alarm.sv
// multi_alarm: N_CH BCD HH:MM alarm channels with per-channel ring/snooze FSMs. Rev 1.0
// Optional snooze logic is built when MULTI_ALARM_SNOOZE_EN is defined.
`default_nettype none

module multi_alarm #(
  parameter int N_CH       = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  localparam int SELW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick_1hz,
  input  logic            c,
  input  logic            btn,
  input  logic [5:0]      cursor,
  input  logic [SELW-1:0] sel_ch,
  input  logic [3:0]      n_min0,
  input  logic [3:0]      n_min1,
  input  logic [3:0]      n_hrs0,
  input  logic [3:0]      n_hrs1,
  input  logic [3:0]      min0,
  input  logic [3:0]      min1,
  input  logic [3:0]      hrs0,
  input  logic [3:0]      hrs1,
  input  logic            en_tgl,
  input  logic            snooze,
  input  logic            stop,
  output logic [3:0]      c_min0,
  output logic [3:0]      c_min1,
  output logic [3:0]      c_hrs0,
  output logic [3:0]      c_hrs1,
  output logic [N_CH-1:0] ch_en,
  output logic [N_CH-1:0] ring,
  output logic            alert
);

  localparam int RW = $clog2(RING_SEC + 1);
`ifdef MULTI_ALARM_SNOOZE_EN
  localparam int SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int SW        = $clog2(SNZ_TICKS + 1);
  localparam int CW        = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
`endif

`ifdef MULTI_ALARM_SNOOZE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RING, ST_SNOOZE} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RING} state_t;
`endif

  logic [3:0] s_min0 [N_CH];
  logic [3:0] s_min1 [N_CH];
  logic [3:0] s_hrs0 [N_CH];
  logic [3:0] s_hrs1 [N_CH];

  state_t        state_q [N_CH];
  state_t        state_d [N_CH];
  logic [RW-1:0] rtim_q  [N_CH];
  logic [RW-1:0] rtim_d  [N_CH];
`ifdef MULTI_ALARM_SNOOZE_EN
  logic [SW-1:0] stim_q  [N_CH];
  logic [SW-1:0] stim_d  [N_CH];
  logic [CW-1:0] scnt_q  [N_CH];
  logic [CW-1:0] scnt_d  [N_CH];
`endif

  logic [N_CH-1:0] match, match_q, fire;
  logic            sel_ok, wr_ok;

  // Read-back mux for the selected channel; also feeds the hour-range check on writes.
  always_comb begin
    sel_ok = (int'(sel_ch) < N_CH);
    c_min0 = 4'd0;
    c_min1 = 4'd0;
    c_hrs0 = 4'd0;
    c_hrs1 = 4'd0;
    if (sel_ok) begin
      c_min0 = s_min0[sel_ch];
      c_min1 = s_min1[sel_ch];
      c_hrs0 = s_hrs0[sel_ch];
      c_hrs1 = s_hrs1[sel_ch];
    end
  end

  always_comb begin
    wr_ok = 1'b0;
    if (c && btn && sel_ok) begin
      case (cursor)
        6'b000100: wr_ok = (n_min0 <= 4'd9);
        6'b001000: wr_ok = (n_min1 <= 4'd5);
        6'b010000: wr_ok = (n_hrs0 <= 4'd9) && !(c_hrs1 == 4'd2 && n_hrs0 > 4'd3);
        6'b100000: wr_ok = (n_hrs1 <= 4'd2) && !(n_hrs1 == 4'd2 && c_hrs0 > 4'd3);
        default:   wr_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        s_min0[i] <= 4'd0;
        s_min1[i] <= 4'd0;
        s_hrs0[i] <= 4'd0;
        s_hrs1[i] <= 4'd0;
      end
    end else if (wr_ok) begin
      case (cursor)
        6'b000100: s_min0[sel_ch] <= n_min0;
        6'b001000: s_min1[sel_ch] <= n_min1;
        6'b010000: s_hrs0[sel_ch] <= n_hrs0;
        6'b100000: s_hrs1[sel_ch] <= n_hrs1;
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      match[i] = (s_min0[i] == min0) && (s_min1[i] == min1) &&
                 (s_hrs0[i] == hrs0) && (s_hrs1[i] == hrs1);
      ring[i]  = (state_q[i] == ST_RING);
      ch_en[i] = (state_q[i] != ST_IDLE);
    end
    fire  = match & ~match_q & {N_CH{~c}};
    alert = |ring;
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      rtim_d[i]  = rtim_q[i];
`ifdef MULTI_ALARM_SNOOZE_EN
      stim_d[i]  = stim_q[i];
      scnt_d[i]  = scnt_q[i];
`endif
      if (en_tgl && sel_ok && sel_ch == SELW'(i)) begin
        state_d[i] = (state_q[i] == ST_IDLE) ? ST_ARMED : ST_IDLE;
        rtim_d[i]  = '0;
      end else begin
        case (state_q[i])
          ST_ARMED: begin
            if (fire[i]) begin
              state_d[i] = ST_RING;
              rtim_d[i]  = RW'(RING_SEC);
`ifdef MULTI_ALARM_SNOOZE_EN
              scnt_d[i]  = '0;
`endif
            end
          end
          ST_RING: begin
            if (stop) begin
              state_d[i] = ST_ARMED;
              rtim_d[i]  = '0;
            end else if (snooze) begin
              rtim_d[i]  = '0;
`ifdef MULTI_ALARM_SNOOZE_EN
              if (MAX_SNOOZE != 0 && int'(scnt_q[i]) >= MAX_SNOOZE) begin
                state_d[i] = ST_ARMED;
              end else begin
                state_d[i] = ST_SNOOZE;
                stim_d[i]  = SW'(SNZ_TICKS);
                // Saturate so the unlimited case cannot wrap the counter.
                if (scnt_q[i] != '1) scnt_d[i] = scnt_q[i] + 1'b1;
              end
`else
              state_d[i] = ST_ARMED;
`endif
            end else if (tick_1hz) begin
              if (rtim_q[i] <= RW'(1)) begin
                state_d[i] = ST_ARMED;
                rtim_d[i]  = '0;
              end else begin
                rtim_d[i]  = rtim_q[i] - 1'b1;
              end
            end
          end
`ifdef MULTI_ALARM_SNOOZE_EN
          ST_SNOOZE: begin
            if (stop) begin
              state_d[i] = ST_ARMED;
              stim_d[i]  = '0;
            end else if (tick_1hz) begin
              if (stim_q[i] <= SW'(1)) begin
                state_d[i] = ST_RING;
                stim_d[i]  = '0;
                rtim_d[i]  = RW'(RING_SEC);
              end else begin
                stim_d[i]  = stim_q[i] - 1'b1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_IDLE;
        rtim_q[i]  <= '0;
`ifdef MULTI_ALARM_SNOOZE_EN
        stim_q[i]  <= '0;
        scnt_q[i]  <= '0;
`endif
      end
    end else begin
      match_q <= match;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        rtim_q[i]  <= rtim_d[i];
`ifdef MULTI_ALARM_SNOOZE_EN
        stim_q[i]  <= stim_d[i];
        scnt_q[i]  <= scnt_d[i];
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_alarm.sv
// tb_multi_alarm: directed self-checking bench for multi_alarm (default parameters).
`default_nettype none

module tb_multi_alarm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0, c = 1'b0, btn = 1'b0;
  logic [5:0] cursor = 6'd0;
  logic [1:0] sel_ch = 2'd0;
  logic [3:0] n_min0 = 4'd0, n_min1 = 4'd0, n_hrs0 = 4'd0, n_hrs1 = 4'd0;
  logic [3:0] min0 = 4'd0, min1 = 4'd0, hrs0 = 4'd0, hrs1 = 4'd0;
  logic       en_tgl = 1'b0, snooze = 1'b0, stop = 1'b0;
  logic [3:0] c_min0, c_min1, c_hrs0, c_hrs1;
  logic [3:0] ch_en, ring;
  logic       alert;

  int errors = 0;
  int checks = 0;

  multi_alarm dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .c(c), .btn(btn), .cursor(cursor),
    .sel_ch(sel_ch), .n_min0(n_min0), .n_min1(n_min1), .n_hrs0(n_hrs0), .n_hrs1(n_hrs1),
    .min0(min0), .min1(min1), .hrs0(hrs0), .hrs1(hrs1), .en_tgl(en_tgl),
    .snooze(snooze), .stop(stop), .c_min0(c_min0), .c_min1(c_min1), .c_hrs0(c_hrs0),
    .c_hrs1(c_hrs1), .ch_en(ch_en), .ring(ring), .alert(alert)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
      step();
    end
  endtask

  task automatic wr_digit(input int ch, input logic [5:0] cur, input logic [3:0] v);
    sel_ch = ch[1:0];
    cursor = cur;
    n_min0 = v; n_min1 = v; n_hrs0 = v; n_hrs1 = v;
    btn = 1'b1;
    step();
    btn = 1'b0;
  endtask

  task automatic set_alarm(input int ch, input logic [15:0] hhmm);
    wr_digit(ch, 6'b100000, hhmm[15:12]);
    wr_digit(ch, 6'b010000, hhmm[11:8]);
    wr_digit(ch, 6'b001000, hhmm[7:4]);
    wr_digit(ch, 6'b000100, hhmm[3:0]);
  endtask

  task automatic rd(input int ch, output logic [15:0] v);
    sel_ch = ch[1:0];
    #1;
    v = {c_hrs1, c_hrs0, c_min1, c_min0};
  endtask

  task automatic set_time(input logic [15:0] hhmm);
    {hrs1, hrs0, min1, min0} = hhmm;
  endtask

  task automatic toggle(input int ch);
    sel_ch = ch[1:0];
    en_tgl = 1'b1;
    step();
    en_tgl = 1'b0;
  endtask

  logic [15:0] v;

  initial begin
    #2 rst = 1'b0;
    #10;
    check("reset_ring", ring, 4'b0000);
    check("reset_alert", alert, 1'b0);
    check("reset_ch_en", ch_en, 4'b0000);
    rd(0, v);
    check("reset_setting", v, 16'h0000);
    step();
    rst = 1'b1;
    step();

    // Program ch1 = 07:30 and probe rejected writes.
    c = 1'b1;
    set_alarm(1, 16'h0730);
    rd(1, v);
    check("wr_0730", v, 16'h0730);
    wr_digit(1, 6'b001000, 4'd6);
    rd(1, v);
    check("min1_6_dropped", v, 16'h0730);
    wr_digit(1, 6'b100000, 4'd3);
    rd(1, v);
    check("hrs1_3_dropped", v, 16'h0730);
    wr_digit(1, 6'b100000, 4'd2);
    rd(1, v);
    check("hrs_27_dropped", v, 16'h0730);
    wr_digit(1, 6'b000011, 4'd1);
    rd(1, v);
    check("bad_cursor", v, 16'h0730);
    wr_digit(3, 6'b100000, 4'd2);
    wr_digit(3, 6'b010000, 4'd5);
    rd(3, v);
    check("hrs_25_dropped", v, 16'h2000);
    wr_digit(3, 6'b010000, 4'd3);
    rd(3, v);
    check("hrs_23_ok", v, 16'h2300);
    wr_digit(3, 6'b000100, 4'd9);
    rd(3, v);
    check("min0_9_ok", v, 16'h2309);

    toggle(1);
    check("ch1_enabled", ch_en, 4'b0010);
    c = 1'b0;
    set_time(16'h0729);
    step();
    check("no_ring_0729", ring, 4'b0000);
    set_time(16'h0730);
    #1;
    check("no_comb_path", ring, 4'b0000);
    step();
    check("ring_ch1", ring, 4'b0010);
    check("alert_on", alert, 1'b1);

    ticks(59);
    check("ring_tick59", ring, 4'b0010);
    ticks(1);
    check("autostop_tick60", ring, 4'b0000);
    check("autostop_ch_en", ch_en, 4'b0010);
    ticks(5);
    check("no_refire", ring, 4'b0000);

    // Re-trigger ch1 with a fresh minute edge.
    set_time(16'h0731);
    step();
    set_time(16'h0730);
    step();
    check("ring_again", ring, 4'b0010);
`ifdef MULTI_ALARM_SNOOZE_EN
    for (int k = 1; k <= 3; k++) begin
      snooze = 1'b1;
      step();
      snooze = 1'b0;
      check("snooze_ring_off", ring, 4'b0000);
      check("snooze_ch_en", ch_en, 4'b0010);
      ticks(299);
      check("snooze_tick299", ring, 4'b0000);
      ticks(1);
      check("snooze_reringing", ring, 4'b0010);
    end
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    check("snooze4_stops", ring, 4'b0000);
    ticks(300);
    check("snooze4_armed", ring, 4'b0000);
    check("snooze4_ch_en", ch_en, 4'b0010);
`else
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    check("snooze_as_stop", ring, 4'b0000);
    ticks(60);
    check("snooze_as_stop_hold", ring, 4'b0000);
    check("snooze_as_stop_ch_en", ch_en, 4'b0010);
`endif

    // Two channels at 12:00; stop and snooze together must not snooze.
    c = 1'b1;
    set_alarm(0, 16'h1200);
    set_alarm(2, 16'h1200);
    toggle(0);
    toggle(2);
    check("ch_en_three", ch_en, 4'b0111);
    c = 1'b0;
    set_time(16'h1200);
    step();
    check("ring_ch0_ch2", ring, 4'b0101);
    stop = 1'b1;
    snooze = 1'b1;
    step();
    stop = 1'b0;
    snooze = 1'b0;
    check("stop_snooze_off", ring, 4'b0000);
    ticks(300);
    check("stop_wins", ring, 4'b0000);
    toggle(1);
    check("ch1_disabled", ch_en, 4'b0101);

    // A match edge seen while in set mode must not fire later.
    set_time(16'h1159);
    step();
    c = 1'b1;
    set_time(16'h1200);
    step();
    check("set_mode_blocks", ring, 4'b0000);
    c = 1'b0;
    step();
    check("no_late_fire", ring, 4'b0000);

    set_time(16'h1159);
    step();
    set_time(16'h1200);
    step();
    check("ring_before_rst", ring, 4'b0101);
    rst = 1'b0;
    #1;
    check("async_alert_off", alert, 1'b0);
    check("async_ch_en_off", ch_en, 4'b0000);
    rd(0, v);
    check("rst_ch0_cleared", v, 16'h0000);
    rd(1, v);
    check("rst_ch1_cleared", v, 16'h0000);
    rd(3, v);
    check("rst_ch3_cleared", v, 16'h0000);
    step();
    rst = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
